// File: rtl/funnel_shifter_pkg.sv
// rtl/funnel_shifter_pkg.sv - shared widths, control encodings and amount helper for the funnel shifter
package funnel_shifter_pkg;

    localparam int DATA_W   = 32;
    localparam int FUNNEL_W = 64;
    localparam int AMT_W    = 6;

    typedef enum logic [2:0] {
        SHR_L = 3'b000,
        SHR_A = 3'b001,
        ROR   = 3'b010,
        ROL   = 3'b011,
        SHL   = 3'b100
    } shift_ctrl_e;

    // Left operations shift the funnel right by 32-shamt; shamt=0 lands on k=32 (pure hi word).
    function automatic logic [AMT_W-1:0] left_amount(input logic [4:0] shamt);
        left_amount = 6'd32 - {1'b0, shamt};
    endfunction

endpackage

// File: rtl/funnel_core.sv
// rtl/funnel_core.sv - combinational 64-to-32 right funnel, six-stage logarithmic mux
module funnel_core
    import funnel_shifter_pkg::*;
(
    input  logic [FUNNEL_W-1:0] i_funnel,
    input  logic [AMT_W-1:0]    i_k,
    output logic [DATA_W-1:0]   o_y
);

    logic [FUNNEL_W-1:0] w_stage [0:AMT_W];

    assign w_stage[0] = i_funnel;

    // Stage s conditionally moves the word right by 2**s; zeros entering from the top never reach the low half for k<=32.
    genvar s;
    generate
        for (s = 0; s < AMT_W; s++) begin : g_stage
            assign w_stage[s+1] = i_k[s] ? (w_stage[s] >> (1 << s)) : w_stage[s];
        end
    endgenerate

    assign o_y = w_stage[AMT_W][DATA_W-1:0];

endmodule

// File: rtl/funnel_shifter_32.sv
// rtl/funnel_shifter_32.sv - registered 32-bit shifter/rotator; rotates enabled by FUNNEL_SHIFTER_ROTATE_EN
module funnel_shifter_32
    import funnel_shifter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] a,
    input  logic        [4:0]        shamt,
    input  logic        [2:0]        control,
    output logic        [DATA_W-1:0] y
);

    logic [DATA_W-1:0] w_hi;
    logic [DATA_W-1:0] w_lo;
    logic [AMT_W-1:0]  w_k;
    logic [AMT_W-1:0]  w_k_left;
    logic [DATA_W-1:0] w_y;
    logic [DATA_W-1:0] r_y;

    assign w_k_left = left_amount(shamt);

    always_comb begin
        w_hi = '0;
        w_lo = a;
        w_k  = {1'b0, shamt};
        case (control)
            SHR_L: begin
                w_hi = '0;
            end
            SHR_A: begin
                w_hi = {DATA_W{a[DATA_W-1]}};
            end
`ifdef FUNNEL_SHIFTER_ROTATE_EN
            ROR: begin
                w_hi = a;
            end
            ROL: begin
                w_hi = a;
                w_k  = w_k_left;
            end
`else
            // Without rotates, 010/011 fall back to the right shifts selected by control[0].
            ROR: begin
                w_hi = '0;
            end
            ROL: begin
                w_hi = {DATA_W{a[DATA_W-1]}};
            end
`endif
            default: begin
                w_hi = a;
                w_lo = '0;
                w_k  = w_k_left;
            end
        endcase
    end

    funnel_core u_core (
        .i_funnel ({w_hi, w_lo}),
        .i_k      (w_k),
        .o_y      (w_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y <= '0;
        end else begin
            r_y <= w_y;
        end
    end

    assign y = r_y;

endmodule

// File: tb/tb_funnel_shifter_32.sv
// tb/tb_funnel_shifter_32.sv - scoreboard bench for funnel_shifter_32 (honours FUNNEL_SHIFTER_ROTATE_EN)
module tb_funnel_shifter_32;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [2:0]  control;
    logic [31:0] y;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        n_tests;
    int        n_fail;

    funnel_shifter_32 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .shamt   (shamt),
        .control (control),
        .y       (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] golden(input logic [31:0] ga, input logic [4:0] gs, input logic [2:0] gc);
        logic [63:0] dbl;
        dbl = {ga, ga};
        case (gc)
            3'b000: golden = ga >> gs;
            3'b001: golden = $unsigned($signed(ga) >>> gs);
`ifdef FUNNEL_SHIFTER_ROTATE_EN
            3'b010: golden = dbl[31:0] >> gs | dbl[31:0] << (6'd32 - {1'b0, gs});
            3'b011: begin
                dbl = dbl << gs;
                golden = dbl[63:32];
            end
`else
            3'b010: golden = ga >> gs;
            3'b011: golden = $unsigned($signed(ga) >>> gs);
`endif
            default: golden = ga << gs;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One cycle per call: check the op driven last cycle, then drive and queue the next one.
    task automatic step(input string tag, input logic [31:0] ia, input logic [4:0] is,
                        input logic [2:0] ic, input logic ir, input logic [31:0] exp);
        sb_entry_t e;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, y, e.exp);
        end
        a       = ia;
        shamt   = is;
        control = ic;
        rst_n   = ir;
        e.tag   = tag;
        e.exp   = ir ? exp : 32'h0;
        sb_q.push_back(e);
    endtask

    localparam logic [31:0] A0 = 32'hFE000021;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        a = '0; shamt = '0; control = '0; rst_n = 1'b0;

        step("reset0", A0, 5'd4, 3'b100, 1'b0, 32'h0);
        step("reset1", A0, 5'd4, 3'b001, 1'b0, 32'h0);

        step("shr_l4", A0, 5'd4, 3'b000, 1'b1, 32'h0FE00002);
        step("shr_a4", A0, 5'd4, 3'b001, 1'b1, 32'hFFE00002);
        for (int c = 4; c < 8; c++) begin
            step($sformatf("shl4_c%0d", c), A0, 5'd4, c[2:0], 1'b1, 32'hE0000210);
            step($sformatf("shl31_c%0d", c), A0, 5'd31, c[2:0], 1'b1, 32'h80000000);
        end
`ifdef FUNNEL_SHIFTER_ROTATE_EN
        step("ror4", A0, 5'd4, 3'b010, 1'b1, 32'h1FE00002);
        step("rol4", A0, 5'd4, 3'b011, 1'b1, 32'hE000021F);
`else
        step("c010_4", A0, 5'd4, 3'b010, 1'b1, 32'h0FE00002);
        step("c011_4", A0, 5'd4, 3'b011, 1'b1, 32'hFFE00002);
`endif
        for (int c = 0; c < 8; c++) begin
            step($sformatf("zero_c%0d", c), A0, 5'd0, c[2:0], 1'b1, 32'hFE000021);
        end

        for (int c = 0; c < 8; c++) begin
            for (int s = 0; s < 32; s++) begin
                logic [31:0] va;
                va = (s % 3 == 0) ? A0 : $urandom;
                if (c == 3 && s == 17) begin
                    step("mid_reset", va, s[4:0], c[2:0], 1'b0, 32'h0);
                end else begin
                    step($sformatf("sweep_c%0d_s%0d", c, s), va, s[4:0], c[2:0], 1'b1,
                         golden(va, s[4:0], c[2:0]));
                end
            end
        end

        step("flush", A0, 5'd0, 3'b000, 1'b1, 32'hFE000021);
        @(negedge clk);
        if (sb_q.size() > 0) begin
            sb_entry_t e;
            e = sb_q.pop_front();
            check_eq(e.tag, y, e.exp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/funnel_shifter_32.md
FUNNEL_SHIFTER_32 -- requirements
Module: funnel_shifter_32

Interface
REQ-001 The port clk SHALL be an input, 1 bit wide, and act as the single clock; all state updates SHALL occur on its rising edge.
REQ-002 The port rst_n SHALL be an input, 1 bit wide, and act as a synchronous, active-low reset.
REQ-003 The port a SHALL be an input, 32 bits wide, signed, and carry the operand to be shifted.
REQ-004 The port shamt SHALL be an input, 5 bits wide, unsigned, and carry the shift amount 0..31.
REQ-005 The port control SHALL be an input, 3 bits wide, and select the operation.
REQ-006 The port y SHALL be an output, 32 bits wide, and carry the registered result.

Function
REQ-007 The control encodings SHALL be:
- 000: logical right shift (zero fill).
- 001: arithmetic right shift (sign fill from a[31]).
- 010: rotate right.
- 011: rotate left.
- 1xx: logical left shift (zero fill); 100, 101, 110 and 111 are all identical.
REQ-008 The block SHALL compute all operations through a single 64-bit funnel: a {hi,lo} word shifted right by a 6-bit amount k, with y taking the low 32 bits of the result.
REQ-009 Each operation SHALL load the funnel as follows:
- Logical right: hi=0, lo=a, k=shamt.
- Arithmetic right: hi={32{a[31]}}, lo=a, k=shamt.
- Rotate right: hi=a, lo=a, k=shamt.
- Left shift: hi=a, lo=0, k=32-shamt.
- Rotate left: hi=a, lo=a, k=32-shamt.
REQ-010 With shamt=0, every operation SHALL yield y=a; for left operations this SHALL be handled by k=32, with no special-case bypass required.
REQ-011 The shift amount SHALL be taken modulo 32 by construction; no overflow or saturation flag SHALL exist.
REQ-012 The result SHALL be registered into y, giving a latency of exactly 1 clock: inputs sampled at edge N SHALL appear on y after edge N.
REQ-013 The block SHALL accept a new operation every cycle (throughput 1/clk) with no handshake.
REQ-014 Any change of a, shamt or control SHALL affect only the next registered value; no combinational path from inputs to y SHALL exist.

Reset
REQ-015 While rst_n=0 at a rising edge, y SHALL become 32'h0000_0000.
REQ-016 Reset SHALL override any operation presented in the same cycle; the first valid result SHALL appear one edge after rst_n returns to 1.
REQ-017 Reset SHALL have no asynchronous effect.

Configuration
REQ-018 The macro FUNNEL_SHIFTER_ROTATE_EN, when defined, SHALL enable the rotate encodings 010 (ROR) and 011 (ROL) per REQ-009.
REQ-019 When FUNNEL_SHIFTER_ROTATE_EN is undefined, 010 SHALL behave as 000 (logical right) and 011 SHALL behave as 001 (arithmetic right), and no rotate logic SHALL be synthesized.

Structure
REQ-020 The package funnel_shifter_pkg SHALL hold:
- the width constant DATA_W=32;
- an enum/typedef for the 3-bit control encodings (SHR_L, SHR_A, ROR, ROL, SHL);
- the funnel width constant FUNNEL_W=64.
REQ-021 The sub-module funnel_core SHALL implement the combinational 64-to-32 right shifter with a 6-bit amount, built as a 6-stage logarithmic mux.
REQ-022 The top level SHALL contain only the operand/amount selection and the output register.

Verification (a=32'hFE000021 unless stated)
REQ-023 control=000, shamt=4 -> y=32'h0FE00002 one cycle later; control=001, shamt=4 -> y=32'hFFE00002.
REQ-024 control=100, 101, 110 or 111 with shamt=4 -> y=32'hE0000210; with shamt=31 -> y=32'h80000000.
REQ-025 With FUNNEL_SHIFTER_ROTATE_EN defined: control=010, shamt=4 -> y=32'h1FE00002; control=011, shamt=4 -> y=32'hE000021F.
REQ-026 shamt=0 under each of the 8 control codes -> y=32'hFE000021.
REQ-027 Sweep shamt 0..31 for every code against a golden model (>>, >>>, <<, rotates), checking the 1-cycle latency.
REQ-028 Assert rst_n=0 mid-sweep -> y=0 at the next edge; on release, the next edge shows the correct result.
